game_ctrl: RTL



---
 rtl/game_pkg.sv | 22 ++
 rtl/lfsr10.sv | 15 +
 rtl/game_ctrl.sv | 121 ++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// Shared geometry constants and brick state encoding for the frame-rate game logic.
package game_pkg;

   localparam int unsigned SCREEN_W   = 640;
   localparam int unsigned SCREEN_H   = 480;
   localparam int unsigned BOARD_W    = 64;
   localparam int unsigned BOARD_Y    = 464;
   localparam int unsigned BOARD_STEP = 4;
   localparam int unsigned BRICK_SIZE = 50;
   localparam int unsigned BRICK_STEP = 2;

   localparam int unsigned BOARD_X_MAX = SCREEN_W - BOARD_W;
   localparam int unsigned BRICK_X_MAX = SCREEN_W - BRICK_SIZE;

   typedef enum logic [1:0] {
      FALL  = 2'd0,
      DROP  = 2'd1,
      CATCH = 2'd2,
      MISS  = 2'd3
   } state_t;

endpackage

// File: rtl/lfsr10.sv
// Free-running 10-bit Fibonacci LFSR, polynomial x^10 + x^7 + 1; SEED must be non-zero.
module lfsr10 #(
   parameter logic [9:0] SEED = 10'h1A5
) (
   input  logic       dclk,
   input  logic       rst,
   output logic [9:0] lfsr
);

   always_ff @(posedge dclk or posedge rst) begin
      if (rst) lfsr <= SEED;
      else     lfsr <= {lfsr[8:0], lfsr[9] ^ lfsr[6]};
   end

endmodule

// File: rtl/game_ctrl.sv
// Per-frame game logic: board motion, falling brick, catch/miss scoring and brick respawn.
module game_ctrl
   import game_pkg::*;
#(
   parameter logic [9:0] LFSR_SEED = 10'h1A5
) (
   input  logic       dclk,
   input  logic       rst,
   input  logic       vsync,
   input  logic       btn_left,
   input  logic       btn_right,
   output logic [9:0] board_x,
   output logic [9:0] board_y,
   output logic [9:0] brick_x,
   output logic [9:0] brick_y,
   output logic [7:0] score,
   output logic [3:0] misses,
   output logic       frame_tick
);

   logic        vsync_d;
   logic        tick;
   logic [1:0]  left_sync;
   logic [1:0]  right_sync;
   logic        left_s;
   logic        right_s;
   state_t      state;
   logic [9:0]  lfsr;
   logic [9:0]  respawn_x;
   logic [9:0]  board_nx;
   logic [10:0] board_dec;
   logic [10:0] board_inc;
   logic [10:0] y_new;
   logic        overlap;

   lfsr10 #(.SEED(LFSR_SEED)) u_lfsr (
      .dclk (dclk),
      .rst  (rst),
      .lfsr (lfsr)
   );

   assign board_y = 10'(BOARD_Y);
   assign tick    = vsync & ~vsync_d;
   assign left_s  = left_sync[1];
   assign right_s = right_sync[1];

   // Values above the right limit fold into 79..511, always a legal left edge.
   assign respawn_x = (lfsr > 10'(BRICK_X_MAX)) ? (lfsr - 10'd512) : lfsr;

   always_comb begin
      board_nx  = board_x;
      board_dec = {1'b0, board_x} - 11'(BOARD_STEP);
      board_inc = {1'b0, board_x} + 11'(BOARD_STEP);
      if (left_s && !right_s)
         board_nx = board_dec[10] ? '0 : board_dec[9:0];
      else if (right_s && !left_s)
         board_nx = (board_inc > 11'(BOARD_X_MAX)) ? 10'(BOARD_X_MAX) : board_inc[9:0];
   end

   // Catch test deliberately uses the board position from before this tick's move.
   always_comb begin
      y_new   = {1'b0, brick_y} + 11'(BRICK_STEP);
      overlap = ({1'b0, brick_x} < ({1'b0, board_x} + 11'(BOARD_W))) &&
                (({1'b0, brick_x} + 11'(BRICK_SIZE)) > {1'b0, board_x});
   end

   always_ff @(posedge dclk or posedge rst) begin
      if (rst) begin
         vsync_d    <= 1'b1;
         frame_tick <= 1'b0;
         left_sync  <= '0;
         right_sync <= '0;
         board_x    <= 10'd288;
         brick_x    <= 10'd295;
         brick_y    <= '0;
         score      <= '0;
         misses     <= '0;
         state      <= FALL;
      end else begin
         vsync_d    <= vsync;
         frame_tick <= tick;
         left_sync  <= {left_sync[0], btn_left};
         right_sync <= {right_sync[0], btn_right};
         if (tick) begin
            board_x <= board_nx;
            case (state)
               FALL: begin
                  if ((y_new + 11'(BRICK_SIZE)) >= 11'(BOARD_Y)) begin
                     if (overlap) begin
                        brick_y <= 10'(BOARD_Y - BRICK_SIZE);
                        if (score != '1) score <= score + 8'd1;
                        state   <= CATCH;
                     end else begin
                        brick_y <= y_new[9:0];
                        state   <= DROP;
                     end
                  end else begin
                     brick_y <= y_new[9:0];
                  end
               end
               DROP: begin
                  if ((y_new + 11'(BRICK_SIZE)) >= 11'(SCREEN_H)) begin
                     brick_y <= 10'(SCREEN_H - BRICK_SIZE);
                     if (misses != '1) misses <= misses + 4'd1;
                     state   <= MISS;
                  end else begin
                     brick_y <= y_new[9:0];
                  end
               end
               CATCH, MISS: begin
                  brick_y <= '0;
                  brick_x <= respawn_x;
                  state   <= FALL;
               end
               default: state <= FALL;
            endcase
         end
      end
   end

endmodule
